// File: rtl/scaler_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scaler_gate_ctrl
// Purpose  : Counts one-shot rising edges over back-to-back gate windows and
//            streams a per-window snapshot out one channel per beat.
// Revision : 1.0
// ============================================================================
module scaler_gate_ctrl #(
    parameter int NCH      = 12,
    parameter int CH_W     = 4,
    parameter int CNT_W    = 16,
    parameter int PERIOD_W = 32
) (
    input  logic                clk250_i,
    input  logic                rst_n_i,
    input  logic [NCH-1:0]      scal_i,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic [CNT_W-1:0]    dout_o,
    output logic [CH_W-1:0]     dch_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                done_o,
    output logic                missed_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(NCH - 1);
    localparam logic [PERIOD_W-1:0] ONE_TICK = PERIOD_W'(1);

    state_t              state;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] load_val;
    logic [NCH-1:0]      prev;
    logic [NCH-1:0]      edges;
    logic [CNT_W-1:0]    live   [NCH];
    logic [CNT_W-1:0]    shadow [NCH];
    logic [CNT_W-1:0]    cand   [NCH];
    logic [CH_W-1:0]     ptr;
    logic [CH_W-1:0]     ptr_next;
    logic                snap_cycle;
    logic                last_accept;
    logic                readout_idle;
    logic                take_snap;

    assign edges    = scal_i & ~prev;
    assign load_val = (period_i == '0) ? ONE_TICK : period_i;
    assign ptr_next = ptr + CH_W'(1);

    // Candidate includes this cycle's edge so the snapshot cycle closes the gate.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
            assign cand[gi] = (live[gi] == CNT_MAX) ? CNT_MAX
                                                    : live[gi] + CNT_W'(edges[gi]);
        end
    endgenerate

    assign snap_cycle   = (state == GATE) && enable_i && (timer == ONE_TICK);
    assign last_accept  = valid_o && ready_i && (ptr == LAST_CH);
    assign readout_idle = !valid_o || last_accept;
    assign take_snap    = snap_cycle && readout_idle;

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev <= '0;
        end else begin
            prev <= scal_i;
        end
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            timer <= '0;
            for (int i = 0; i < NCH; i++) live[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    for (int i = 0; i < NCH; i++) live[i] <= '0;
                    if (enable_i) begin
                        timer <= load_val;
                        state <= GATE;
                    end
                end
                GATE: begin
                    if (!enable_i) begin
                        state <= IDLE;
                        for (int i = 0; i < NCH; i++) live[i] <= '0;
                    end else if (timer == ONE_TICK) begin
                        timer <= load_val;
                        for (int i = 0; i < NCH; i++) live[i] <= '0;
                    end else begin
                        timer <= timer - ONE_TICK;
                        for (int i = 0; i < NCH; i++) live[i] <= cand[i];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A snapshot landing on the final accept restarts the readout seamlessly.
    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr      <= '0;
            valid_o  <= 1'b0;
            dch_o    <= '0;
            dout_o   <= '0;
            done_o   <= 1'b0;
            missed_o <= 1'b0;
            for (int i = 0; i < NCH; i++) shadow[i] <= '0;
        end else begin
            done_o <= take_snap;
            if (snap_cycle && !readout_idle) begin
                missed_o <= 1'b1;
            end
            if (take_snap) begin
                for (int i = 0; i < NCH; i++) shadow[i] <= cand[i];
                ptr     <= '0;
                valid_o <= 1'b1;
                dch_o   <= '0;
                dout_o  <= cand[0];
            end else if (valid_o && ready_i) begin
                if (ptr == LAST_CH) begin
                    valid_o <= 1'b0;
                    ptr     <= '0;
                    dch_o   <= '0;
                    dout_o  <= '0;
                end else begin
                    ptr    <= ptr_next;
                    dch_o  <= ptr_next;
                    dout_o <= shadow[ptr_next];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scaler_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scaler_gate_ctrl
// Purpose  : Scoreboard bench for scaler_gate_ctrl; directed gate scenarios.
// Revision : 1.0
// ============================================================================
module tb_scaler_gate_ctrl;

    localparam int NCH   = 12;
    localparam int CH_W  = 4;
    localparam int CNT_W = 16;
    localparam int PW    = 32;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] val;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    scal;
    logic              enable;
    logic [PW-1:0]     period;
    logic [CNT_W-1:0]  dout;
    logic [CH_W-1:0]   dch;
    logic              valid;
    logic              ready;
    logic              done;
    logic              missed;

    logic [NCH-1:0]    scal4;
    logic              en4;
    logic [PW-1:0]     period4;
    logic [3:0]        dout4;
    logic [CH_W-1:0]   dch4;
    logic              valid4;
    logic              ready4;
    logic              done4;
    logic              missed4;

    beat_t             q[$];
    beat_t             q4[$];
    beat_t             b;
    beat_t             b4;
    logic [CNT_W-1:0]  exp_vals [NCH];
    int                checks   = 0;
    int                failures = 0;
    int                done_cnt = 0;
    int                cyc      = 0;
    int                base;
    logic              stall    = 1'b0;
    logic [CH_W-1:0]   saved_dch;
    logic [CNT_W-1:0]  saved_dout;

    always #2 clk = ~clk;

    scaler_gate_ctrl #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W), .PERIOD_W(PW)) dut (
        .clk250_i(clk), .rst_n_i(rst_n), .scal_i(scal), .enable_i(enable),
        .period_i(period), .dout_o(dout), .dch_o(dch), .valid_o(valid),
        .ready_i(ready), .done_o(done), .missed_o(missed)
    );

    scaler_gate_ctrl #(.NCH(NCH), .CH_W(CH_W), .CNT_W(4), .PERIOD_W(PW)) dut4 (
        .clk250_i(clk), .rst_n_i(rst_n), .scal_i(scal4), .enable_i(en4),
        .period_i(period4), .dout_o(dout4), .dch_o(dch4), .valid_o(valid4),
        .ready_i(ready4), .done_o(done4), .missed_o(missed4)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: pops one expected beat per accepted beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (valid && stall) begin
                check("stall_dch_stable", dch, saved_dch);
                check("stall_dout_stable", dout, saved_dout);
            end
            stall      = valid && !ready;
            saved_dch  = dch;
            saved_dout = dout;
            if (valid && ready) begin
                if (q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    b = q.pop_front();
                    check("beat_dch", dch, b.ch);
                    check($sformatf("beat_ch%0d_dout", b.ch), dout, b.val);
                end
            end
            if (valid4 && ready4) begin
                if (q4.size() == 0) begin
                    check("extra_beat_cnt4", 1, 0);
                end else begin
                    b4 = q4.pop_front();
                    check("beat4_dch", dch4, b4.ch);
                    check($sformatf("beat4_ch%0d_dout", b4.ch), dout4, b4.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int k);
        while (cyc < k) tick();
    endtask

    task automatic push_gate();
        for (int i = 0; i < NCH; i++) begin
            q.push_back('{ch: CH_W'(i), val: exp_vals[i]});
            exp_vals[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        en4    = 1'b0;
        scal   = '0;
        scal4  = '0;
        repeat (3) tick();
        rst_n  = 1'b1;
        repeat (2) tick();
    endtask

    task automatic start_gate();
        enable = 1'b1;
        cyc    = 0;
        tick();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || q4.size() != 0 || valid || valid4) && n < 400) begin
            tick();
            n++;
        end
        check(name, q.size() + q4.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NCH; i++) exp_vals[i] = '0;
        ready   = 1'b1;
        ready4  = 1'b1;
        period  = '0;
        period4 = '0;

        // Reset values
        do_reset();
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        check("rst_missed", missed, 0);
        check("rst_dout", dout, 0);
        check("rst_dch", dch, 0);

        // Single pulse; second snapshot coincides with the last accept
        period = 12;
        exp_vals[3] = 1;
        push_gate();
        push_gate();
        base = done_cnt;
        start_gate();
        goto(3);  scal[3] = 1'b1;
        tick();   scal[3] = 1'b0;
        goto(30); enable = 1'b0;
        wait_drain("t1_drain");
        repeat (10) tick();
        check("t1_done_count", done_cnt - base, 2);
        check("t1_missed", missed, 0);

        // Held-high input counts once; 50 rises on ch1
        do_reset();
        period = 100;
        exp_vals[0] = 1;
        exp_vals[1] = 50;
        push_gate();
        base = done_cnt;
        start_gate();
        for (int k = 1; k <= 100; k++) begin
            scal[0] = (k <= 20);
            scal[1] = (k % 2 == 1);
            tick();
        end
        scal = '0;
        goto(105); enable = 1'b0;
        wait_drain("t2_drain");
        check("t2_done_count", done_cnt - base, 1);

        // Edge on the snapshot cycle belongs to the closing gate
        do_reset();
        period = 14;
        exp_vals[5] = 1;
        push_gate();
        push_gate();
        base = done_cnt;
        start_gate();
        goto(14); scal[5] = 1'b1;
        tick();   scal[5] = 1'b0;
        goto(35); enable = 1'b0;
        wait_drain("t3_drain");
        check("t3_done_count", done_cnt - base, 2);
        check("t3_missed", missed, 0);

        // Long stall: later snapshot dropped, shadow preserved
        do_reset();
        period = 16;
        ready  = 1'b0;
        exp_vals[7] = 1;
        push_gate();
        base = done_cnt;
        start_gate();
        goto(2);  scal[7] = 1'b1;
        tick();   scal[7] = 1'b0;
        goto(20); scal[8] = 1'b1;
        tick();   scal[8] = 1'b0;
        goto(47);
        check("t4_missed_set", missed, 1);
        ready  = 1'b1;
        enable = 1'b0;
        wait_drain("t4_drain");
        check("t4_done_count", done_cnt - base, 1);
        check("t4_missed_sticky", missed, 1);

        // period 0 behaves as 1-cycle gates
        do_reset();
        period = 0;
        exp_vals[4] = 1;
        push_gate();
        exp_vals[6] = 1;
        push_gate();
        base = done_cnt;
        start_gate();
        scal[4] = 1'b1;
        tick();   scal[4] = 1'b0;
        goto(13); scal[6] = 1'b1;
        tick();   scal[6] = 1'b0;
        goto(20); enable = 1'b0;
        wait_drain("t5_drain");
        check("t5_done_count", done_cnt - base, 2);
        check("t5_missed", missed, 1);

        // 4-bit counters saturate at 15
        do_reset();
        period4 = 50;
        for (int i = 0; i < NCH; i++)
            q4.push_back('{ch: CH_W'(i), val: (i == 2) ? CNT_W'(15) : CNT_W'(0)});
        en4 = 1'b1;
        cyc = 0;
        tick();
        for (int k = 1; k <= 50; k++) begin
            scal4[2] = (k % 2 == 1) && (k <= 39);
            tick();
        end
        scal4 = '0;
        goto(60); en4 = 1'b0;
        wait_drain("t5b_drain");

        // Reset asserted mid-readout
        do_reset();
        period = 12;
        exp_vals[9] = 1;
        push_gate();
        start_gate();
        goto(2);  scal[9] = 1'b1;
        tick();   scal[9] = 1'b0;
        goto(17);
        check("t6_valid_before_reset", valid, 1);
        rst_n  = 1'b0;
        enable = 1'b0;
        q.delete();
        #1;
        check("t6_rst_valid", valid, 0);
        check("t6_rst_dout", dout, 0);
        check("t6_rst_dch", dch, 0);
        check("t6_rst_done", done, 0);
        base = done_cnt;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("t6_no_beat_after_reset", valid, 0);
        check("t6_no_done_after_reset", done_cnt - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
